// File: rtl/raid_pkg.sv
// Shared types and default sizing for the RAID host arbiter.
package raid_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MH    = 2'd1,
        ST_SH    = 2'd2,
        ST_DRAIN = 2'd3
    } arb_state_t;

    localparam int DEF_TIMEOUT_W = 16;
    localparam int DEF_GAP_CYC   = 2;

endpackage

// File: rtl/raid_sat_counter.sv
// Saturating up-counter with synchronous clear; o_nxt exposes the value the
// next edge will load so callers can act in the same cycle a limit is reached.
module raid_sat_counter
    import raid_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt,
    output logic [W-1:0] o_nxt
);

    logic [W-1:0] r_cnt;

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v, input logic inc);
        if (inc && (v != {W{1'b1}}))
            return v + W'(1);
        return v;
    endfunction

    assign o_nxt = i_clr ? '0 : sat_inc(r_cnt, i_inc);
    assign o_cnt = r_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else
            r_cnt <= o_nxt;
    end

endmodule

// File: rtl/raid_host_arbiter.sv
// Main/secondary host arbiter for a mirrored flash pair, with SH session
// timeout, post-session drain gap and fairness. Grant statistics counters are
// built only when RAID_ARB_STATS_EN is defined; otherwise the count ports read 0.
module raid_host_arbiter
    import raid_pkg::*;
#(
    parameter int TIMEOUT_W = DEF_TIMEOUT_W,
    parameter int GAP_CYC   = DEF_GAP_CYC
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mh_req,
    input  logic                 sh_req,
    input  logic                 sh_enable,
    input  logic                 flash_busy,
    input  logic [TIMEOUT_W-1:0] timeout_lim,
    output logic                 grant_mh,
    output logic                 grant_sh,
    output logic                 timeout_evt,
    output logic [1:0]           arb_state,
    output logic [7:0]           mh_grant_cnt,
    output logic [7:0]           sh_grant_cnt
);

    // A zero gap still spends one non-busy DRAIN cycle before IDLE.
    localparam int GAP_LIM = (GAP_CYC < 1) ? 1 : GAP_CYC;
    localparam int GAP_W   = $clog2(GAP_LIM + 1);

    arb_state_t           r_state;
    logic                 r_grant_mh;
    logic                 r_grant_sh;
    logic                 r_timeout_evt;
    logic                 r_last_mh;
    logic                 r_sh_kill;
    logic [GAP_W-1:0]     r_gap;

    logic                 w_sh_elig;
    logic                 w_go_mh;
    logic                 w_go_sh;
    logic                 w_gap_done;
    logic                 w_tmo_hit;
    logic [TIMEOUT_W-1:0] w_tmo_cnt;
    logic [TIMEOUT_W-1:0] w_tmo_nxt;

    assign w_sh_elig  = sh_req && sh_enable && !r_sh_kill;
    assign w_go_mh    = (r_state == ST_IDLE) && mh_req && (!w_sh_elig || !r_last_mh);
    assign w_go_sh    = (r_state == ST_IDLE) && w_sh_elig && (!mh_req || r_last_mh);
    assign w_gap_done = (r_gap == GAP_W'(GAP_LIM - 1));

    // Wait cycles of MH during an SH session; held at zero outside SH.
    raid_sat_counter #(.W(TIMEOUT_W)) u_tmo_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (r_state != ST_SH),
        .i_inc (mh_req),
        .o_cnt (w_tmo_cnt),
        .o_nxt (w_tmo_nxt)
    );

    assign w_tmo_hit = (r_state == ST_SH) && (timeout_lim != '0) && (w_tmo_nxt == timeout_lim);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_grant_mh    <= 1'b0;
            r_grant_sh    <= 1'b0;
            r_timeout_evt <= 1'b0;
            r_last_mh     <= 1'b0;
            r_sh_kill     <= 1'b0;
            r_gap         <= '0;
        end else begin
            r_timeout_evt <= 1'b0;
            if (!sh_req)
                r_sh_kill <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_go_mh) begin
                        r_state    <= ST_MH;
                        r_grant_mh <= 1'b1;
                        r_last_mh  <= 1'b1;
                    end else if (w_go_sh) begin
                        r_state    <= ST_SH;
                        r_grant_sh <= 1'b1;
                        r_last_mh  <= 1'b0;
                    end
                end
                ST_MH: begin
                    if (!mh_req) begin
                        r_state    <= ST_DRAIN;
                        r_grant_mh <= 1'b0;
                        r_gap      <= '0;
                    end
                end
                ST_SH: begin
                    // Timeout wins over a simultaneous enable drop so the event is not lost.
                    if (w_tmo_hit) begin
                        r_state       <= ST_DRAIN;
                        r_grant_sh    <= 1'b0;
                        r_timeout_evt <= 1'b1;
                        r_sh_kill     <= 1'b1;
                        r_gap         <= '0;
                    end else if (!sh_req || !sh_enable) begin
                        r_state    <= ST_DRAIN;
                        r_grant_sh <= 1'b0;
                        r_gap      <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (flash_busy) begin
                        r_gap <= '0;
                    end else if (w_gap_done) begin
                        r_state <= ST_IDLE;
                        r_gap   <= '0;
                    end else begin
                        r_gap <= r_gap + GAP_W'(1);
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_grant_mh <= 1'b0;
                    r_grant_sh <= 1'b0;
                end
            endcase
        end
    end

    assign grant_mh    = r_grant_mh;
    assign grant_sh    = r_grant_sh;
    assign timeout_evt = r_timeout_evt;
    assign arb_state   = r_state;

`ifdef RAID_ARB_STATS_EN
    logic [7:0] w_unused_mh_nxt;
    logic [7:0] w_unused_sh_nxt;

    raid_sat_counter #(.W(8)) u_mh_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (1'b0),
        .i_inc (w_go_mh),
        .o_cnt (mh_grant_cnt),
        .o_nxt (w_unused_mh_nxt)
    );

    raid_sat_counter #(.W(8)) u_sh_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (1'b0),
        .i_inc (w_go_sh),
        .o_cnt (sh_grant_cnt),
        .o_nxt (w_unused_sh_nxt)
    );
`else
    assign mh_grant_cnt = 8'd0;
    assign sh_grant_cnt = 8'd0;
`endif

endmodule

// File: doc/raid_host_arbiter.md
RAID_HOST_ARBITER -- requirements
Module: raid_host_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_W, default 16, width of the session timeout counter and limit.
REQ-002 SHALL have parameter GAP_CYC, default 2, minimum idle cycles between grants.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port mh_req  input  1  main host session active (synchronized CS asserted).
REQ-006 SHALL have port sh_req  input  1  secondary host session active (synchronized CS asserted).
REQ-007 SHALL have port sh_enable  input  1  management permits the secondary host.
REQ-008 SHALL have port flash_busy  input  1  flash sequencer still completing a mirrored operation.
REQ-009 SHALL have port timeout_lim  input  TIMEOUT_W  maximum SH session cycles while MH waits; 0 disables timeout.
REQ-010 SHALL have port grant_mh  output  1  main host owns the flash pair.
REQ-011 SHALL have port grant_sh  output  1  secondary host owns the flash pair.
REQ-012 SHALL have port timeout_evt  output  1  one-cycle pulse on forced SH release.
REQ-013 SHALL have port arb_state  output  2  current FSM state encoding.
REQ-014 SHALL have port mh_grant_cnt  output  8  MH grant count.
REQ-015 SHALL have port sh_grant_cnt  output  8  SH grant count.

Function
REQ-016 SHALL implement FSM states IDLE=0, MH=1, SH=2, DRAIN=3; arb_state SHALL reflect the registered state.
REQ-017 grant_mh SHALL be 1 exactly when state=MH, and grant_sh exactly when state=SH; the two SHALL never be 1 together.
REQ-018 IDLE: with mh_req only, SHALL go to MH; with eligible sh_req only, SHALL go to SH; grant SHALL appear one cycle after the request is sampled.
REQ-019 sh_req SHALL be eligible only when sh_enable=1 and sh_kill=0.
REQ-020 IDLE with both requests eligible: SHALL grant SH if last_mh=1, else MH (alternating fairness); last_mh SHALL update on every grant.
REQ-021 MH: SHALL stay while mh_req=1; on mh_req=0 SHALL go to DRAIN; no preemption.
REQ-022 SH: SHALL stay while sh_req=1; on sh_req=0 or sh_enable=0 SHALL go to DRAIN.
REQ-023 SH: tmo_cnt SHALL count cycles with mh_req=1, reset on SH entry, and saturate; at tmo_cnt==timeout_lim (nonzero) SHALL pulse timeout_evt, set sh_kill, and go to DRAIN.
REQ-024 sh_kill SHALL clear only in a cycle where sh_req=0.
REQ-025 DRAIN: SHALL count cycles with flash_busy=0 and go to IDLE after GAP_CYC consecutive such cycles; flash_busy=1 SHALL restart the count.
REQ-026 Requests arriving during DRAIN SHALL be held off and arbitrated in IDLE, not dropped.
REQ-027 If sh_enable falls and timeout fires in the same cycle, timeout_evt SHALL still pulse.

Reset
REQ-028 On rst=1 at a clock edge: state=IDLE, grant_mh=0, grant_sh=0, timeout_evt=0, last_mh=0, sh_kill=0, tmo_cnt=0, gap counter=0, both grant counters=0.
REQ-029 Reset mid-session SHALL drop the grant the following cycle with no DRAIN pass.

Configuration
REQ-030 With macro RAID_ARB_STATS_EN defined, mh_grant_cnt and sh_grant_cnt SHALL increment on each IDLE-to-MH and IDLE-to-SH transition respectively, saturating at 255.
REQ-031 Without RAID_ARB_STATS_EN, both count ports SHALL be tied to 0 and no counter flops SHALL be synthesized; all other behaviour SHALL be identical.

Structure
REQ-032 Package raid_pkg SHALL hold arb_state_t (2-bit enum of the four states) and the default TIMEOUT_W and GAP_CYC constants.
REQ-033 Sub-module raid_sat_counter (parameterized width, inc, saturate) SHALL implement the stats counters and tmo_cnt.

Verification
REQ-034 mh_req=1 in IDLE -> grant_mh=1 next cycle; drop mh_req -> DRAIN; IDLE after 2 idle cycles; mh_grant_cnt=1.
REQ-035 Both requests in IDLE after reset -> MH granted; after release with both still requesting -> SH granted (fairness).
REQ-036 SH granted, timeout_lim=10, mh_req held 1 -> timeout_evt pulses on the 10th wait cycle; grant_sh=0; MH granted after drain; sh_req re-eligible only after it falls.
REQ-037 DRAIN with flash_busy=1 for 5 cycles -> no grant until 5+2 cycles have elapsed.
REQ-038 rst=1 during SH session -> grant_sh=0 and counts=0 next cycle; sh_enable=0 with sh_req=1 -> never granted.
REQ-039 Assertion over all tests: grant_mh & grant_sh never 1 together; counters stop at 255 after 300 grants (stats build).
